// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, keyboard command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_ACK,
    ST_WAIT_REL,
    ST_DONE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // PS/2 uses odd parity: the nine bits {parity, data} hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: shift-register glitch filter on the clock line, 2-flop data synchroniser,
// and a one-cycle pulse on each filtered falling clock edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic filt,
  output logic ps2d_sync,
  output logic fall
);

  logic [FILTER_LEN-1:0] shreg_q, shreg_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;
  logic [1:0]            dsync_q, dsync_d;

  // Filter output only moves once the whole window agrees; mixed windows hold the last level.
  always_comb begin
    shreg_d = {ps2c_in, shreg_q[FILTER_LEN-1:1]};
    filt_d  = filt_q;
    if (&shreg_q) begin
      filt_d = 1'b1;
    end else if (~|shreg_q) begin
      filt_d = 1'b0;
    end
    fall_d  = filt_q & ~filt_d;
    dsync_d = {dsync_q[0], ps2d_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      dsync_q <= 2'b11;
    end else begin
      shreg_q <= shreg_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      dsync_q <= dsync_d;
    end
  end

  assign filt      = filt_q;
  assign ps2d_sync = dsync_q[1];
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_tx_host.sv
// Host-to-device PS/2 byte transmitter driving open-drain pull-low enables.
// Build option: define PS2_TX_TIMEOUT_EN to add a watchdog on the device clock.
module ps2_tx_host
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 13000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  // Handshake: a request is taken on any clock edge where tx_start=1 and tx_idle=1;
  // din is captured on that same edge and tx_start is ignored whenever tx_idle=0.
  input  logic       tx_start,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CNT_W = (RTS_CYCLES > 2) ? $clog2(RTS_CYCLES) : 1;

  if (RTS_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 2) begin : g_param_check
    $error("ps2_tx_host: RTS_CYCLES, TIMEOUT_CYCLES and FILTER_LEN must all be >= 2");
  end

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nbit_q, nbit_d;
  logic [8:0]       shreg_q, shreg_d;
  logic             ack_ok_q, ack_ok_d;
  logic             ps2c_oe_q, ps2c_oe_d;
  logic             ps2d_oe_q, ps2d_oe_d;
  logic             tx_idle_q, tx_idle_d;
  logic             tx_done_tick_q, tx_done_tick_d;
  logic             tx_err_q, tx_err_d;

  logic filt, ps2d_sync, fall;
  logic timeout_hit;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .filt     (filt),
    .ps2d_sync(ps2d_sync),
    .fall     (fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_run;

  // Counts only while the device owns the clock; every falling edge proves it is still alive.
  always_comb begin
    wd_run = state_q inside {ST_START, ST_DATA, ST_STOP, ST_ACK, ST_WAIT_REL};
    wd_d   = '0;
    if (wd_run && !fall) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign timeout_hit = wd_run && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbit_d   = nbit_q;
    shreg_d  = shreg_q;
    ack_ok_d = ack_ok_q;
    tx_err_d = tx_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shreg_d  = {odd_parity(din), din};
          cnt_d    = CNT_W'(RTS_CYCLES - 1);
          ack_ok_d = 1'b0;
          tx_err_d = 1'b0;
          state_d  = ST_RTS;
        end
      end
      ST_RTS: begin
        if (cnt_q == '0) begin
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_START: begin
        if (fall) begin
          nbit_d  = 4'd8;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_d = {1'b0, shreg_q[8:1]};
          if (nbit_q == 4'd0) begin
            state_d = ST_STOP;
          end else begin
            nbit_d = nbit_q - 1'b1;
          end
        end
      end
      // The device pulls data low before its 11th falling edge and holds it through that pulse.
      ST_STOP: begin
        if (fall) begin
          ack_ok_d = ~ps2d_sync;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (filt) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (filt && ps2d_sync) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout_hit) begin
      ack_ok_d = 1'b0;
      state_d  = ST_DONE;
    end

    if (state_d == ST_DONE) begin
      tx_err_d = ~ack_ok_d;
    end

    // Outputs are decoded from the next state so they are registered and glitch-free on the pads.
    ps2c_oe_d      = (state_d == ST_RTS);
    ps2d_oe_d      = (state_d == ST_START) | ((state_d == ST_DATA) & ~shreg_d[0]);
    tx_idle_d      = (state_d == ST_IDLE);
    tx_done_tick_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      nbit_q         <= '0;
      shreg_q        <= '0;
      ack_ok_q       <= 1'b0;
      ps2c_oe_q      <= 1'b0;
      ps2d_oe_q      <= 1'b0;
      tx_idle_q      <= 1'b1;
      tx_done_tick_q <= 1'b0;
      tx_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      nbit_q         <= nbit_d;
      shreg_q        <= shreg_d;
      ack_ok_q       <= ack_ok_d;
      ps2c_oe_q      <= ps2c_oe_d;
      ps2d_oe_q      <= ps2d_oe_d;
      tx_idle_q      <= tx_idle_d;
      tx_done_tick_q <= tx_done_tick_d;
      tx_err_q       <= tx_err_d;
    end
  end

  assign ps2c_oe      = ps2c_oe_q;
  assign ps2d_oe      = ps2d_oe_q;
  assign tx_idle      = tx_idle_q;
  assign tx_done_tick = tx_done_tick_q;
  assign tx_err       = tx_err_q;

endmodule
